tile_light_list_fetcher: RTL and testbench

- Read side of the per-tile light-mask RAM filled by the tile light binner.
- Accepts a tile coordinate request from the deferred-shading tile scheduler.
- Reads that tile's MAX_LIGHTS-bit mask through a 1-cycle-latency RAM read port.
- Serialises the set bits into a stream of light IDs, lowest ID first, for the per-tile shading pipeline.

---
 rtl/tile_light_list_fetcher.sv | 156 +++++++++++++++
 tb/tb_tile_light_list_fetcher.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_light_list_fetcher.sv
// Tile light-list fetcher: reads one tile's light mask from the binner's mask RAM
// and serialises its set bits into light IDs, lowest ID first.
// Optional build macro TILE_FETCH_CLEAR_ON_READ_EN adds a write port that zeroes
// the tile's mask in the cycle it is captured, ready for the next frame.
module tile_light_list_fetcher #(
  parameter int SCREEN_W   = 1920,
  parameter int SCREEN_H   = 1080,
  parameter int TILE_W     = 16,
  parameter int TILE_H     = 16,
  parameter int MAX_LIGHTS = 32,
  parameter int NTX        = (SCREEN_W + TILE_W - 1) / TILE_W,
  parameter int NTY        = (SCREEN_H + TILE_H - 1) / TILE_H,
  parameter int ADDR_W     = $clog2(NTX * NTY),
  parameter int LID_W      = $clog2(MAX_LIGHTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_tx,
  input  logic [7:0]            req_ty,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [MAX_LIGHTS-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LID_W-1:0]      out_light_id,
  output logic                  out_last,
  output logic                  out_empty,
  output logic                  busy
`ifdef TILE_FETCH_CLEAR_ON_READ_EN
  ,
  output logic                  mem_wr_en,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [MAX_LIGHTS-1:0] mem_wr_data
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_EMIT} state_t;

  localparam logic [31:0] NTX_U = 32'(NTX);
  localparam logic [31:0] NTY_U = 32'(NTY);

  state_t                r_state;
  logic [7:0]            r_tx;
  logic [7:0]            r_ty;
  logic [MAX_LIGHTS-1:0] r_pending;
  logic                  r_out_valid;
  logic [LID_W-1:0]      r_id;
  logic                  r_last;
  logic                  r_empty;

  logic                  w_in_range;
  logic [MAX_LIGHTS-1:0] w_next_pending;

  // Index of the lowest set bit; zero for an empty mask.
  function automatic logic [LID_W-1:0] lowest_idx(input logic [MAX_LIGHTS-1:0] m);
    logic [LID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_LIGHTS - 1; i >= 0; i--) begin
      if (m[i]) idx = LID_W'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit of the mask is set.
  function automatic logic is_single(input logic [MAX_LIGHTS-1:0] m);
    return (m != '0) && ((m & (m - MAX_LIGHTS'(1))) == '0);
  endfunction

  assign w_in_range     = ({24'd0, req_tx} < NTX_U) && ({24'd0, req_ty} < NTY_U);
  // Clearing the lowest set bit retires the ID currently presented.
  assign w_next_pending = r_pending & (r_pending - MAX_LIGHTS'(1));

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign mem_rd_en    = (r_state == S_RD);
  // Full-width row-major address, truncated to the RAM address width.
  assign mem_rd_addr  = ADDR_W'(32'(r_ty) * NTX_U + 32'(r_tx));
  assign out_valid    = r_out_valid;
  assign out_light_id = r_id;
  assign out_last     = r_last;
  assign out_empty    = r_empty;

`ifdef TILE_FETCH_CLEAR_ON_READ_EN
  // RAM is read-before-write, so zeroing in the capture cycle cannot corrupt the captured mask.
  assign mem_wr_en   = (r_state == S_CAP);
  assign mem_wr_addr = mem_rd_addr;
  assign mem_wr_data = '0;
`endif

  // Request/read/capture/emit sequencer with registered beat outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tx        <= '0;
      r_ty        <= '0;
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_id        <= '0;
      r_last      <= 1'b0;
      r_empty     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_tx <= req_tx;
            r_ty <= req_ty;
            if (w_in_range) begin
              r_state <= S_RD;
            end else begin
              // Off-screen tile: answer with a single empty beat, no RAM access.
              r_state     <= S_EMIT;
              r_pending   <= '0;
              r_out_valid <= 1'b1;
              r_id        <= '0;
              r_last      <= 1'b1;
              r_empty     <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_state <= S_CAP;
        end
        S_CAP: begin
          r_state     <= S_EMIT;
          r_pending   <= mem_rd_data;
          r_out_valid <= 1'b1;
          r_id        <= lowest_idx(mem_rd_data);
          r_last      <= (mem_rd_data == '0) || is_single(mem_rd_data);
          r_empty     <= (mem_rd_data == '0);
        end
        S_EMIT: begin
          if (out_ready) begin
            if (r_last) begin
              r_state     <= S_IDLE;
              r_pending   <= '0;
              r_out_valid <= 1'b0;
              r_id        <= '0;
              r_last      <= 1'b0;
              r_empty     <= 1'b0;
            end else begin
              r_pending <= w_next_pending;
              r_id      <= lowest_idx(w_next_pending);
              r_last    <= is_single(w_next_pending);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_light_list_fetcher.sv
// Directed bench for tile_light_list_fetcher with a behavioural mask RAM and
// a queue of expected light-ID beats.
module tb_tile_light_list_fetcher;

  localparam int ADDR_W = 13;

  typedef struct packed {
    logic [4:0] id;
    logic       last;
    logic       empty;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [7:0]        req_tx;
  logic [7:0]        req_ty;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_light_id;
  logic              out_last;
  logic              out_empty;
  logic              busy;
`ifdef TILE_FETCH_CLEAR_ON_READ_EN
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
`endif

  logic [31:0]       ram [0:8191];
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  tile_light_list_fetcher dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_tx       (req_tx),
    .req_ty       (req_ty),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_light_id (out_light_id),
    .out_last     (out_last),
    .out_empty    (out_empty),
    .busy         (busy)
`ifdef TILE_FETCH_CLEAR_ON_READ_EN
    ,
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mask RAM: 1-cycle read latency, read-before-write, bench-side preload port.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    if (ld_en) ram[ld_addr] <= ld_data;
`ifdef TILE_FETCH_CLEAR_ON_READ_EN
    else if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
`endif
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic exp_beat(input int id, input logic last, input logic empty);
    beat_t b;
    b.id = 5'(id); b.last = last; b.empty = empty;
    q.push_back(b);
  endtask

  // Issues a request; returns at the negedge of the cycle after acceptance.
  task automatic send_req(input logic [7:0] tx, input logic [7:0] ty);
    req_valid = 1'b1; req_tx = tx; req_ty = ty;
    chk("req_ready_at_issue", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Pops and compares every handshaken beat until the queue empties or the budget runs out.
  task automatic drain(output int cycles);
    beat_t e;
    int budget;
    budget = 200;
    cycles = 0;
    while (q.size() > 0 && budget > 0) begin
      if (out_valid && out_ready) begin
        e = q.pop_front();
        chk("beat_id", {27'd0, out_light_id}, {27'd0, e.id});
        chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
        chk("beat_empty", {31'd0, out_empty}, {31'd0, e.empty});
      end
      tick();
      cycles++;
      budget--;
    end
    if (q.size() != 0) begin
      chk("drain_timeout_left", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0; req_valid = 1'b0; req_tx = '0; req_ty = '0;
    out_ready = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_id", {27'd0, out_light_id}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_empty", {31'd0, out_empty}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Tile (0,0) mask 0x5: ids 0,2 at T+3/T+4; a request while busy is ignored
    load(0, 32'h0000_0005);
    exp_beat(0, 1'b0, 1'b0);
    exp_beat(2, 1'b1, 1'b0);
    send_req(8'd0, 8'd0);
    chk("t1_rd_en_T1", {31'd0, mem_rd_en}, 32'd1);
    chk("t1_rd_addr_T1", 32'(mem_rd_addr), 32'd0);
    chk("t1_busy_T1", {31'd0, busy}, 32'd1);
    chk("t1_req_ready_T1", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1; req_tx = 8'd7; req_ty = 8'd7;
    tick();
    req_valid = 1'b0;
    chk("t1_rd_en_T2", {31'd0, mem_rd_en}, 32'd0);
    chk("t1_out_valid_T2", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t1_out_valid_T3", {31'd0, out_valid}, 32'd1);
    drain(c);
    chk("t1_beat_cycles", c, 2);
    chk("t1_req_ready_T5", {31'd0, req_ready}, 32'd1);
    chk("t1_out_valid_T5", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t1_no_stray_beat", {31'd0, out_valid}, 32'd0);
    chk("t1_no_stray_read", {31'd0, mem_rd_en}, 32'd0);

    // Tile (3,2) empty mask: address 243, single empty beat
    load(243, 32'h0);
    exp_beat(0, 1'b1, 1'b1);
    send_req(8'd3, 8'd2);
    chk("t2_rd_addr", 32'(mem_rd_addr), 32'd243);
    chk("t2_rd_en", {31'd0, mem_rd_en}, 32'd1);
    tick(); tick();
    drain(c);
    chk("t2_req_ready_after", {31'd0, req_ready}, 32'd1);

    // Sparse mask 0x00A40000: ids 18,21,23
    load(50, 32'h00A4_0000);
    exp_beat(18, 1'b0, 1'b0);
    exp_beat(21, 1'b0, 1'b0);
    exp_beat(23, 1'b1, 1'b0);
    send_req(8'd50, 8'd0);
    chk("t3_rd_addr", 32'(mem_rd_addr), 32'd50);
    tick(); tick();
    drain(c);
    chk("t3_beat_cycles", c, 3);

    // Full mask on tile (10,1): 32 back-to-back beats
    load(130, 32'hFFFF_FFFF);
    for (int i = 0; i < 32; i++) exp_beat(i, (i == 31), 1'b0);
    send_req(8'd10, 8'd1);
    chk("t4_rd_addr", 32'(mem_rd_addr), 32'd130);
    tick(); tick();
    drain(c);
    chk("t4_beat_cycles", c, 32);

    // Mask 0x80000001 with 4-cycle stall on the first beat
    load(11, 32'h8000_0001);
    exp_beat(0, 1'b0, 1'b0);
    exp_beat(31, 1'b1, 1'b0);
    send_req(8'd11, 8'd0);
    tick();
    out_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t5_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_stall_id", {27'd0, out_light_id}, 32'd0);
      chk("t5_stall_last", {31'd0, out_last}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    drain(c);
    chk("t5_beat_cycles", c, 2);

    // Out-of-range tile (120,0): empty beat at T+1, no read
    exp_beat(0, 1'b1, 1'b1);
    send_req(8'd120, 8'd0);
    chk("t6_rd_en_T1", {31'd0, mem_rd_en}, 32'd0);
    chk("t6_out_valid_T1", {31'd0, out_valid}, 32'd1);
    drain(c);
    chk("t6_beat_cycles", c, 1);
    chk("t6_rd_en_after", {31'd0, mem_rd_en}, 32'd0);

    // Reset in the middle of EMIT abandons the tile
    load(1, 32'h0000_00F0);
    send_req(8'd1, 8'd0);
    tick();
    out_ready = 1'b0;
    tick();
    chk("t7_valid_before_rst", {31'd0, out_valid}, 32'd1);
    chk("t7_id_before_rst", {27'd0, out_light_id}, 32'd4);
    rst_n = 1'b0;
    tick();
    chk("t7_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t7_rst_out_id", {27'd0, out_light_id}, 32'd0);
    chk("t7_rst_out_last", {31'd0, out_last}, 32'd0);
    chk("t7_rst_out_empty", {31'd0, out_empty}, 32'd0);
    chk("t7_rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("t7_rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("t7_rst_busy", {31'd0, busy}, 32'd0);
    chk("t7_rst_req_ready", {31'd0, req_ready}, 32'd1);
    out_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("t7_post_req_ready", {31'd0, req_ready}, 32'd1);
    chk("t7_post_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t7_post_rd_en", {31'd0, mem_rd_en}, 32'd0);

`ifdef TILE_FETCH_CLEAR_ON_READ_EN
    // Clear-on-read: tile 5 mask 0x10 emits id 4 and is zeroed in the capture cycle
    load(5, 32'h0000_0010);
    exp_beat(4, 1'b1, 1'b0);
    send_req(8'd5, 8'd0);
    chk("t8_wr_en_T1", {31'd0, mem_wr_en}, 32'd0);
    tick();
    chk("t8_wr_en_T2", {31'd0, mem_wr_en}, 32'd1);
    chk("t8_wr_addr_T2", 32'(mem_wr_addr), 32'd5);
    chk("t8_wr_data_T2", mem_wr_data, 32'd0);
    tick();
    chk("t8_wr_en_T3", {31'd0, mem_wr_en}, 32'd0);
    drain(c);
    exp_beat(0, 1'b1, 1'b1);
    send_req(8'd5, 8'd0);
    tick(); tick();
    drain(c);
    exp_beat(0, 1'b1, 1'b1);
    send_req(8'd200, 8'd0);
    chk("t8_oor_wr_en", {31'd0, mem_wr_en}, 32'd0);
    drain(c);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
